// File: rtl/load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | Module      : load_store_unit                                               |
// | Description : RV32I memory-access stage. Issues one request/grant/response  |
// |               transaction per load/store, lane-aligns store data, extracts  |
// |               and extends load data, and reports misaligned, timeout and    |
// |               illegal-funct3 faults. Stalls the core while busy.            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // execute-stage instruction
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  // core control / writeback
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  // data-memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // The counter holds the number of bus cycles already spent, so the last
  // permitted cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Registered state
  logic [2:0]  state_q,    state_d;
  logic [31:0] addr_q,     addr_d;
  logic [2:0]  funct3_q,   funct3_d;
  logic        is_load_q,  is_load_d;
  logic [3:0]  strb_q,     strb_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [7:0]  tmo_q,      tmo_d;
  logic        mem_req_q,  mem_req_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q,  wb_data_d;
  logic        fault_q,    fault_d;
  logic [1:0]  cause_q,    cause_d;

  // Decode of the incoming instruction
  logic        start;
  logic        req_illegal;
  logic        req_misaligned;
  logic [3:0]  req_strb;
  logic [31:0] req_wdata;

  // Load data extraction
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  // Timeout reached on this cycle
  logic        tmo_hit;

  assign start   = ex_valid & (ex_load | ex_store);
  assign tmo_hit = (tmo_q == TMO_LAST);

  // Classify the incoming access and build its byte lanes.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    req_strb       = 4'b0000;
    req_wdata      = ex_wdata;

    if (ex_load) begin
      case (ex_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
        default:                                req_illegal = 1'b1;
      endcase
    end else begin
      case (ex_funct3)
        3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
        default:                req_illegal = 1'b1;
      endcase
    end

    // funct3[1:0] encodes access size for both loads and stores
    case (ex_funct3[1:0])
      2'b01:   req_misaligned = ex_addr[0];
      2'b10:   req_misaligned = |ex_addr[1:0];
      default: req_misaligned = 1'b0;
    endcase

    // Stores replicate the datum on every lane; the strobe picks the lane.
    if (ex_store) begin
      case (ex_funct3[1:0])
        2'b00: begin
          req_strb  = 4'b0001 << ex_addr[1:0];
          req_wdata = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          req_strb  = 4'b0011 << ex_addr[1:0];
          req_wdata = {2{ex_wdata[15:0]}};
        end
        default: begin
          req_strb  = 4'b1111;
          req_wdata = ex_wdata;
        end
      endcase
    end
  end

  // Select the addressed byte/half of the returned word and extend it.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase

    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'h000000, ld_byte};
      3'b101:  ld_value = {16'h0000, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  // Transaction sequencing, timeout and output-pulse generation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    is_load_d  = is_load_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    tmo_d      = tmo_q;
    wb_data_d  = wb_data_q;
    cause_d    = cause_q;
    mem_req_d  = 1'b0;
    wb_valid_d = 1'b0;
    fault_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = ex_addr;
          funct3_d  = ex_funct3;
          is_load_d = ex_load;
          strb_d    = req_strb;
          wdata_d   = req_wdata;
          if (req_illegal) begin
            state_d = S_ERR;
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (req_misaligned) begin
            state_d = S_ERR;
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
            tmo_d     = 8'd0;
          end
        end
      end

      S_REQ: begin
        tmo_d = tmo_q + 8'd1;
        // A completion on the timeout cycle still completes.
        if (!is_load_q && mem_gnt) begin
          state_d = S_DONE;
        end else if (is_load_q && mem_gnt && mem_rvalid) begin
          state_d    = S_DONE;
          wb_valid_d = 1'b1;
          wb_data_d  = ld_value;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else if (mem_gnt) begin
          state_d = S_WAIT;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      S_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        if (mem_rvalid) begin
          state_d    = S_DONE;
          wb_valid_d = 1'b1;
          wb_data_d  = ld_value;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops mem_req without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'h0;
      funct3_q   <= 3'b000;
      is_load_q  <= 1'b0;
      strb_q     <= 4'b0000;
      wdata_q    <= 32'h0;
      tmo_q      <= 8'd0;
      mem_req_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'h0;
      fault_q    <= 1'b0;
      cause_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      is_load_q  <= is_load_d;
      strb_q     <= strb_d;
      wdata_q    <= wdata_d;
      tmo_q      <= tmo_d;
      mem_req_q  <= mem_req_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
    end
  end

  assign stall = ((state_q == S_IDLE) & start) |
                 (state_q == S_REQ) |
                 (state_q == S_WAIT);

  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

  assign mem_req   = mem_req_q;
  assign mem_we    = ~is_load_q & (|strb_q);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = strb_q;

endmodule
`default_nettype wire
